dma_fifo_ctrl: RTL and testbench

Single-channel DMA transfer controller that moves `len` words from a source read port to a destination write port through the existing 16-entry `fifo`. It owns both FIFO ports: a fill engine issues source reads and pushes words into the FIFO, and an independent drain engine pops words and issues destination writes. It sits between the DMA register block, which supplies the descriptor and `start`, and the FIFO/bus interfaces.

---
 rtl/dma_fifo_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dma_fifo_ctrl.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_fifo_ctrl.sv
// Single-channel DMA controller: a fill engine moves source reads into the FIFO, and a drain
// engine moves FIFO words out to destination writes. Both engines run from one clocked block.
module dma_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ack,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ack,
  output logic                  fifo_wen,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_full,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty
);

  localparam logic [ADDR_WIDTH-1:0] Step = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH-1:0]  One  = LEN_WIDTH'(1);

  typedef enum logic [1:0] {FIdle, FWait, FReq, FPush} fill_e;
  typedef enum logic [2:0] {DIdle, DWait, DPop, DWr, DFlush} drain_e;

  fill_e                fill_st_q;
  drain_e               drain_st_q;
  logic [LEN_WIDTH-1:0] fill_cnt_q;
  logic [LEN_WIDTH-1:0] drain_cnt_q;
  logic                 abort_q;
  logic                 abort_act;

  // Abort is live only during an active transfer, not in its final done/aborted cycle.
  always_comb begin
    abort_act = abort_q | (abort & busy & ~done & ~aborted);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      fifo_wen    <= 1'b0;
      fifo_wdata  <= '0;
      fifo_ren    <= 1'b0;
      fill_st_q   <= FIdle;
      drain_st_q  <= DIdle;
      fill_cnt_q  <= '0;
      drain_cnt_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy        <= 1'b1;
          rd_addr     <= src_addr;
          wr_addr     <= dst_addr;
          fill_cnt_q  <= len;
          drain_cnt_q <= len;
          if (abort) begin
            aborted <= 1'b1;
          end else if (len == '0) begin
            done <= 1'b1;
          end else begin
            fill_st_q  <= FWait;
            drain_st_q <= DWait;
          end
        end
      end else if (done || aborted) begin
        busy    <= 1'b0;
        abort_q <= 1'b0;
      end else begin
        abort_q <= abort_act;

        unique case (fill_st_q)
          FIdle: ;
          FWait: begin
            if (abort_act) begin
              fill_st_q <= FIdle;
            end else if (!fifo_full && !fifo_wen) begin
              fill_st_q <= FReq;
              rd_req    <= 1'b1;
            end
          end
          FReq: begin
            // A pending read is always completed; under abort its data is dropped.
            if (rd_ack) begin
              rd_req <= 1'b0;
              if (abort_act) begin
                fill_st_q <= FIdle;
              end else begin
                fifo_wdata <= rd_data;
                fifo_wen   <= 1'b1;
                fill_st_q  <= FPush;
              end
            end
          end
          FPush: begin
            fifo_wen   <= 1'b0;
            rd_addr    <= rd_addr + Step;
            fill_cnt_q <= fill_cnt_q - One;
            if (fill_cnt_q == One || abort_act) begin
              fill_st_q <= FIdle;
            end else begin
              fill_st_q <= FWait;
            end
          end
        endcase

        unique case (drain_st_q)
          DIdle: ;
          DWait: begin
            if (abort_act) begin
              drain_st_q <= DFlush;
            end else if (!fifo_empty && !fifo_ren) begin
              drain_st_q <= DPop;
              fifo_ren   <= 1'b1;
            end
          end
          DPop: begin
            fifo_ren <= 1'b0;
            wr_data  <= fifo_rdata;
            if (abort_act) begin
              drain_st_q <= DFlush;
            end else begin
              drain_st_q <= DWr;
              wr_req     <= 1'b1;
            end
          end
          DWr: begin
            if (wr_ack) begin
              wr_req      <= 1'b0;
              wr_addr     <= wr_addr + Step;
              drain_cnt_q <= drain_cnt_q - One;
              if (drain_cnt_q == One) begin
                drain_st_q <= DIdle;
                done       <= 1'b1;
              end else if (abort_act) begin
                drain_st_q <= DFlush;
              end else begin
                drain_st_q <= DWait;
              end
            end
          end
          DFlush: begin
            // Pop every other cycle so the empty flag is re-read after each pop settles.
            if (fifo_ren) begin
              fifo_ren <= 1'b0;
            end else if (!fifo_empty) begin
              fifo_ren <= 1'b1;
            end else if (fill_st_q == FIdle) begin
              drain_st_q <= DIdle;
              aborted    <= 1'b1;
            end
          end
          default: drain_st_q <= DIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// Bench for dma_fifo_ctrl: behavioural FIFO, randomized bus responders and an
// address/data reference model derived from the transfer descriptor.
module tb_dma_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, aborted;
  logic        rd_req, rd_ack;
  logic [31:0] rd_addr, rd_data;
  logic        wr_req, wr_ack;
  logic [31:0] wr_addr, wr_data;
  logic        fifo_wen, fifo_full, fifo_ren, fifo_empty;
  logic [31:0] fifo_wdata, fifo_rdata;

  always #5 clk = ~clk;

  dma_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty)
  );

  // 16-entry FIFO model, reset together with the controller
  logic [31:0] fmem [16];
  logic [3:0]  fwp, frp;
  logic [4:0]  fcnt;
  always @(posedge clk) begin
    if (rst) begin
      fwp  <= '0;
      frp  <= '0;
      fcnt <= '0;
    end else begin
      if (fifo_wen && fcnt != 5'd16) begin
        fmem[fwp] <= fifo_wdata;
        fwp       <= fwp + 4'd1;
      end
      if (fifo_ren && fcnt != 5'd0) frp <= frp + 4'd1;
      fcnt <= fcnt + 5'(fifo_wen && fcnt != 5'd16) - 5'(fifo_ren && fcnt != 5'd0);
    end
  end
  assign fifo_full  = (fcnt == 5'd16);
  assign fifo_empty = (fcnt == 5'd0);
  assign fifo_rdata = fmem[frp];

  int n_cmp = 0, n_err = 0;
  logic [31:0] seed = 32'h1234_5678;
  int rd_min = 0, rd_max = 0, wr_min = 0, wr_max = 0;
  logic [31:0] rd_log [$];
  logic [31:0] wa_log [$];
  logic [31:0] wd_log [$];
  int done_cnt = 0, abort_cnt = 0, push_cnt = 0, pop_cnt = 0;
  int rdreq_cyc = 0, wrreq_cyc = 0, full_cyc = 0;
  int rd_viol = 0, wr_viol = 0, mon_viol = 0;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // Source read responder: acks after a random delay and checks address stability
  initial begin
    int cnt, dly;
    logic [31:0] hold;
    rd_ack = 1'b0; rd_data = '0; cnt = 0; dly = 0; hold = '0;
    forever begin
      @(negedge clk);
      if (rst || !rd_req) begin
        rd_ack = 1'b0;
        cnt    = 0;
        dly    = int'($urandom_range(rd_max, rd_min));
      end else if (!rd_ack) begin
        if (cnt == 0) hold = rd_addr;
        else if (rd_addr !== hold) rd_viol++;
        if (cnt >= dly) begin
          rd_ack  = 1'b1;
          rd_data = src_word(rd_addr);
          rd_log.push_back(rd_addr);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Destination write responder
  initial begin
    int cnt, dly;
    logic [31:0] hold_a, hold_d;
    wr_ack = 1'b0; cnt = 0; dly = 0; hold_a = '0; hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst || !wr_req) begin
        wr_ack = 1'b0;
        cnt    = 0;
        dly    = int'($urandom_range(wr_max, wr_min));
      end else if (!wr_ack) begin
        if (cnt == 0) begin
          hold_a = wr_addr;
          hold_d = wr_data;
        end else if (wr_addr !== hold_a || wr_data !== hold_d) begin
          wr_viol++;
        end
        if (cnt >= dly) begin
          wr_ack = 1'b1;
          wa_log.push_back(wr_addr);
          wd_log.push_back(wr_data);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Protocol monitor
  initial begin
    bit ren_prev;
    ren_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (fifo_wen && fifo_full) mon_viol++;
        if (fifo_ren && fifo_empty) mon_viol++;
        if (rd_req && fifo_full) mon_viol++;
        if (fifo_ren && ren_prev) mon_viol++;
        if (done && aborted) mon_viol++;
        done_cnt  += int'(done);
        abort_cnt += int'(aborted);
        push_cnt  += int'(fifo_wen);
        pop_cnt   += int'(fifo_ren);
        rdreq_cyc += int'(rd_req);
        wrreq_cyc += int'(wr_req);
        full_cyc  += int'(fifo_full);
      end
      ren_prev = fifo_ren;
    end
  end

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                      input logic ab);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int a0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (done_cnt != d0 || abort_cnt != a0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, aborted, rd_req, wr_req, fifo_wen, fifo_ren} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 0", {busy, done, aborted, rd_req, wr_req, fifo_wen,
               fifo_ren});
    end
    n_cmp++;
    if ({rd_addr, wr_addr, wr_data, fifo_wdata} !== 128'b0) begin
      n_err++;
      $display("FAIL reset_data got %h %h %h %h want 0", rd_addr, wr_addr, wr_data, fifo_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int rb, wb, d0, a0;
    bit ok;
    logic [31:0] ea, ed;
    seed = $urandom; rd_min = 0; rd_max = 0; wr_min = 0; wr_max = 0;
    rb = rd_log.size(); wb = wa_log.size(); d0 = done_cnt; a0 = abort_cnt;
    kick(32'h100, 32'h200, 16'd4, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || rd_req !== 1'b0) begin
      n_err++;
      $display("FAIL basic_accept busy=%b rd_req=%b want 1/0", busy, rd_req);
    end
    @(negedge clk);
    n_cmp++;
    if (rd_req !== 1'b1 || rd_addr !== 32'h100) begin
      n_err++;
      $display("FAIL basic_first_req rd_req=%b rd_addr=%h want 1/00000100", rd_req, rd_addr);
    end
    wait_end(d0, a0, 300, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL basic_timeout got no done want done"); end
    n_cmp++;
    if (rd_log.size() - rb != 4) begin
      n_err++;
      $display("FAIL basic_rd_count got %0d want 4", rd_log.size() - rb);
    end
    for (int i = 0; i < 4 && rb + i < rd_log.size(); i++) begin
      ea = 32'h100 + 32'(4 * i);
      n_cmp++;
      if (rd_log[rb+i] !== ea) begin
        n_err++;
        $display("FAIL basic_rd[%0d] got %h want %h", i, rd_log[rb+i], ea);
      end
    end
    n_cmp++;
    if (wa_log.size() - wb != 4) begin
      n_err++;
      $display("FAIL basic_wr_count got %0d want 4", wa_log.size() - wb);
    end
    for (int i = 0; i < 4 && wb + i < wa_log.size(); i++) begin
      ea = 32'h200 + 32'(4 * i);
      ed = src_word(32'h100 + 32'(4 * i));
      n_cmp++;
      if (wa_log[wb+i] !== ea || wd_log[wb+i] !== ed) begin
        n_err++;
        $display("FAIL basic_wr[%0d] got %h/%h want %h/%h", i, wa_log[wb+i], wd_log[wb+i], ea, ed);
      end
    end
    n_cmp++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done got pulses=%0d busy=%b want 1/0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_len_zero();
    int d0, act0;
    d0 = done_cnt; act0 = rdreq_cyc + wrreq_cyc + push_cnt + pop_cnt;
    kick($urandom, $urandom, 16'd0, 1'b0);
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL len0_done got %b want 1", done); end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL len0_idle done=%b busy=%b want 0/0", done, busy);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (done_cnt - d0 != 1 || rdreq_cyc + wrreq_cyc + push_cnt + pop_cnt != act0) begin
      n_err++;
      $display("FAIL len0_traffic got pulses=%0d activity=%0d want 1/0", done_cnt - d0,
               rdreq_cyc + wrreq_cyc + push_cnt + pop_cnt - act0);
    end
  endtask

  task automatic test_abort_at_start();
    int d0, act0;
    d0 = done_cnt; act0 = rdreq_cyc + wrreq_cyc + push_cnt + pop_cnt;
    kick($urandom, $urandom, 16'd5, 1'b1);
    n_cmp++;
    if (aborted !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_start_pulse aborted=%b done=%b want 1/0", aborted, done);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || aborted !== 1'b0) begin
      n_err++;
      $display("FAIL abort_start_idle busy=%b aborted=%b want 0/0", busy, aborted);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (done_cnt != d0 || rdreq_cyc + wrreq_cyc + push_cnt + pop_cnt != act0) begin
      n_err++;
      $display("FAIL abort_start_traffic got done=%0d activity=%0d want 0/0", done_cnt - d0,
               rdreq_cyc + wrreq_cyc + push_cnt + pop_cnt - act0);
    end
  endtask

  task automatic test_backpressure();
    int wb, d0, a0, f0;
    bit ok;
    logic [31:0] s, d, ea, ed;
    seed = $urandom; rd_min = 0; rd_max = 0; wr_min = 8; wr_max = 8;
    s = $urandom; d = $urandom;
    wb = wa_log.size(); d0 = done_cnt; a0 = abort_cnt; f0 = full_cyc;
    kick(s, d, 16'd40, 1'b0);
    wait_end(d0, a0, 3000, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_timeout got no done want done"); end
    n_cmp++;
    if (full_cyc - f0 <= 0) begin
      n_err++;
      $display("FAIL bp_full_seen got %0d full cycles want >0", full_cyc - f0);
    end
    n_cmp++;
    if (wa_log.size() - wb != 40) begin
      n_err++;
      $display("FAIL bp_wr_count got %0d want 40", wa_log.size() - wb);
    end
    for (int i = 0; i < 40 && wb + i < wa_log.size(); i++) begin
      ea = d + 32'(4 * i);
      ed = src_word(s + 32'(4 * i));
      n_cmp++;
      if (wa_log[wb+i] !== ea || wd_log[wb+i] !== ed) begin
        n_err++;
        $display("FAIL bp_wr[%0d] got %h/%h want %h/%h", i, wa_log[wb+i], wd_log[wb+i], ea, ed);
      end
    end
  endtask

  task automatic test_abort_mid();
    int rb, wb, d0, a0, p0, q0, pushes, nw;
    bit ok;
    logic [31:0] s, d, ea, ed;
    seed = $urandom; rd_min = 3; rd_max = 3; wr_min = 8; wr_max = 8;
    s = $urandom; d = $urandom;
    rb = rd_log.size(); wb = wa_log.size(); d0 = done_cnt; a0 = abort_cnt;
    p0 = push_cnt; q0 = pop_cnt; pushes = 0;
    kick(s, d, 16'd20, 1'b0);
    for (int i = 0; i < 500; i++) begin
      if (pushes >= 5 && rd_req) break;
      @(negedge clk);
      if (fifo_wen) pushes++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_end(d0, a0, 500, ok);
    n_cmp++;
    if (!ok || abort_cnt - a0 != 1 || done_cnt != d0) begin
      n_err++;
      $display("FAIL abort_pulses got ok=%0d aborted=%0d done=%0d want 1/1/0", ok,
               abort_cnt - a0, done_cnt - d0);
    end
    n_cmp++;
    if (push_cnt - p0 != 5 || pop_cnt - q0 != 5) begin
      n_err++;
      $display("FAIL abort_push_pop got %0d/%0d want 5/5", push_cnt - p0, pop_cnt - q0);
    end
    n_cmp++;
    if (rd_log.size() - rb != 6) begin
      n_err++;
      $display("FAIL abort_reads got %0d want 6", rd_log.size() - rb);
    end
    n_cmp++;
    if (fcnt !== 5'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_flushed got fifo=%0d busy=%b want 0/0", fcnt, busy);
    end
    nw = wa_log.size() - wb;
    n_cmp++;
    if (nw > 5) begin n_err++; $display("FAIL abort_wr_count got %0d want <=5", nw); end
    for (int i = 0; i < nw && i < 5; i++) begin
      ea = d + 32'(4 * i);
      ed = src_word(s + 32'(4 * i));
      n_cmp++;
      if (wa_log[wb+i] !== ea || wd_log[wb+i] !== ed) begin
        n_err++;
        $display("FAIL abort_wr[%0d] got %h/%h want %h/%h", i, wa_log[wb+i], wd_log[wb+i], ea, ed);
      end
    end
  endtask

  task automatic test_wrap();
    int rb, wb, d0, a0;
    bit ok;
    logic [31:0] ed;
    seed = $urandom; rd_min = 0; rd_max = 2; wr_min = 0; wr_max = 2;
    rb = rd_log.size(); wb = wa_log.size(); d0 = done_cnt; a0 = abort_cnt;
    kick(32'hFFFF_FFFC, 32'h0000_1000, 16'd2, 1'b0);
    wait_end(d0, a0, 300, ok);
    n_cmp++;
    if (!ok || rd_log.size() - rb != 2) begin
      n_err++;
      $display("FAIL wrap_count got ok=%0d reads=%0d want 1/2", ok, rd_log.size() - rb);
    end else begin
      n_cmp++;
      if (rd_log[rb] !== 32'hFFFF_FFFC || rd_log[rb+1] !== 32'h0) begin
        n_err++;
        $display("FAIL wrap_addr got %h,%h want fffffffc,00000000", rd_log[rb], rd_log[rb+1]);
      end
    end
    n_cmp++;
    ed = src_word(32'h0);
    if (wa_log.size() - wb != 2 || wd_log[wb+1] !== ed) begin
      n_err++;
      $display("FAIL wrap_wr got count=%0d want 2 with last data %h", wa_log.size() - wb, ed);
    end
  endtask

  task automatic test_reset_mid();
    int wb, d0, a0;
    bit ok;
    logic [31:0] ea, ed;
    seed = $urandom; rd_min = 0; rd_max = 2; wr_min = 0; wr_max = 2;
    kick($urandom, $urandom, 16'd30, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, aborted, rd_req, wr_req, fifo_wen, fifo_ren} !== 7'b0 ||
        rd_addr !== 32'h0 || wr_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid got ctrl=%b rd_addr=%h wr_addr=%h want 0", {busy, done, aborted,
               rd_req, wr_req, fifo_wen, fifo_ren}, rd_addr, wr_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    wb = wa_log.size(); d0 = done_cnt; a0 = abort_cnt;
    kick(32'h40, 32'h80, 16'd3, 1'b0);
    wait_end(d0, a0, 300, ok);
    n_cmp++;
    if (!ok || done_cnt - d0 != 1 || wa_log.size() - wb != 3) begin
      n_err++;
      $display("FAIL rst_restart got ok=%0d done=%0d writes=%0d want 1/1/3", ok, done_cnt - d0,
               wa_log.size() - wb);
    end
    for (int i = 0; i < 3 && wb + i < wa_log.size(); i++) begin
      ea = 32'h80 + 32'(4 * i);
      ed = src_word(32'h40 + 32'(4 * i));
      n_cmp++;
      if (wa_log[wb+i] !== ea || wd_log[wb+i] !== ed) begin
        n_err++;
        $display("FAIL rst_wr[%0d] got %h/%h want %h/%h", i, wa_log[wb+i], wd_log[wb+i], ea, ed);
      end
    end
  endtask

  task automatic test_random();
    int rb, wb, d0, a0;
    bit ok;
    logic [31:0] s, d, ea, ed;
    logic [15:0] n;
    for (int it = 0; it < 5; it++) begin
      seed = $urandom;
      rd_min = 0; rd_max = int'($urandom_range(3, 0));
      wr_min = 0; wr_max = int'($urandom_range(3, 0));
      s = $urandom; d = $urandom; n = 16'($urandom_range(24, 1));
      rb = rd_log.size(); wb = wa_log.size(); d0 = done_cnt; a0 = abort_cnt;
      kick(s, d, n, 1'b0);
      wait_end(d0, a0, 2000, ok);
      n_cmp++;
      if (!ok || done_cnt - d0 != 1 || rd_log.size() - rb != int'(n) ||
          wa_log.size() - wb != int'(n)) begin
        n_err++;
        $display("FAIL rand%0d_counts got ok=%0d done=%0d rd=%0d wr=%0d want 1/1/%0d/%0d", it, ok,
                 done_cnt - d0, rd_log.size() - rb, wa_log.size() - wb, n, n);
      end
      for (int i = 0; i < int'(n) && wb + i < wa_log.size(); i++) begin
        ea = d + 32'(4 * i);
        ed = src_word(s + 32'(4 * i));
        n_cmp++;
        if (wa_log[wb+i] !== ea || wd_log[wb+i] !== ed) begin
          n_err++;
          $display("FAIL rand%0d_wr[%0d] got %h/%h want %h/%h", it, i, wa_log[wb+i], wd_log[wb+i],
                   ea, ed);
        end
      end
    end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (rd_viol != 0) begin n_err++; $display("FAIL rd_stable got %0d want 0", rd_viol); end
    n_cmp++;
    if (wr_viol != 0) begin n_err++; $display("FAIL wr_stable got %0d want 0", wr_viol); end
    n_cmp++;
    if (mon_viol != 0) begin n_err++; $display("FAIL fifo_protocol got %0d want 0", mon_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_abort_at_start();
    test_backpressure();
    test_abort_mid();
    test_wrap();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
